count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl_if.sv | 53 +++++
 rtl/count_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_count_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_if.sv
// -----------------------------------------------------------------------------
// count_ctrl_if
// Groups the serial command port and the downstream counter controls of
// count_ctrl into one bundle.
//
//   cs_n      : serial frame select, active-low, asynchronous pin
//   sck       : serial clock, asynchronous pin, data sampled on rising edge
//   mosi      : serial data, MSB first
//   load      : one-cycle load strobe to the counter
//   load_data : value presented with load, held until the next LOAD
//   en        : count enable to the counter
//   oe        : tri-state enable for the counter's q_z output
//   busy      : high while a STEP sequence is in progress
//   err       : sticky unknown-command flag
//
// master : the serial host side (drives the pins, observes the controls)
// slave  : count_ctrl itself
// -----------------------------------------------------------------------------
interface count_ctrl_if;
    logic       cs_n;
    logic       sck;
    logic       mosi;
    logic       load;
    logic [7:0] load_data;
    logic       en;
    logic       oe;
    logic       busy;
    logic       err;

    modport master (
        output cs_n,
        output sck,
        output mosi,
        input  load,
        input  load_data,
        input  en,
        input  oe,
        input  busy,
        input  err
    );

    modport slave (
        input  cs_n,
        input  sck,
        input  mosi,
        output load,
        output load_data,
        output en,
        output oe,
        output busy,
        output err
    );
endinterface

// File: rtl/count_ctrl.sv
// -----------------------------------------------------------------------------
// count_ctrl
// Serial command front end for a downstream counter. A 16-bit frame
// {cmd[7:0], data[7:0]} is shifted in MSB first while cs_n is low and is
// executed once, on the clk edge after the 16th bit lands.
//
// Ports:
//   clk   : single system clock, all state on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : count_ctrl_if.slave -- serial pins in, counter controls out
//
// Commands:
//   0x00 NOP  clear err
//   0x01 LOAD load_data = data, one-cycle load pulse
//   0x02 RUN  en held high
//   0x03 STOP en low
//   0x04 STEP en high for exactly data cycles (data = 0 behaves like STOP)
//   0x05 OE   oe = data[0]
//   other     set err
// -----------------------------------------------------------------------------
module count_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    count_ctrl_if.slave  bus
);

    localparam logic [7:0] CmdNop  = 8'h00;
    localparam logic [7:0] CmdLoad = 8'h01;
    localparam logic [7:0] CmdRun  = 8'h02;
    localparam logic [7:0] CmdStop = 8'h03;
    localparam logic [7:0] CmdStep = 8'h04;
    localparam logic [7:0] CmdOe   = 8'h05;

    localparam logic [4:0] FrameBits = 5'd16;

    typedef enum logic {
        ShIdle,
        ShShift
    } sh_state_e;

    typedef enum logic [1:0] {
        ModeStopped,
        ModeRunning,
        ModeStepping
    } mode_e;

    // -------------------------------------------------------------------------
    // Input synchronizers
    // -------------------------------------------------------------------------
    logic cs_s1_q, cs_s2_q;
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic mosi_s1_q, mosi_s2_q;
    logic sck_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            cs_s1_q   <= bus.cs_n;
            cs_s2_q   <= cs_s1_q;
            sck_s1_q  <= bus.sck;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            mosi_s1_q <= bus.mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sck_rise = sck_s2_q & ~sck_s3_q;

    // -------------------------------------------------------------------------
    // Shift FSM
    // -------------------------------------------------------------------------
    sh_state_e   sh_state_q, sh_state_d;
    logic [15:0] shreg_q, shreg_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        done_q, done_d;
    // The synchronizers reset to 0, which looks like a selected frame. armed
    // only sets once cs_n has been seen high, so a frame is accepted after
    // reset only following a genuine cs_n falling edge.
    logic        armed_q, armed_d;
    logic        exec;
    logic [7:0]  cmd;
    logic [7:0]  data;

    assign exec = (sh_state_q == ShShift) && (bit_cnt_q == FrameBits) && !done_q;
    assign cmd  = shreg_q[15:8];
    assign data = shreg_q[7:0];

    always_comb begin
        sh_state_d = sh_state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = done_q | exec;
        armed_d    = armed_q | cs_s2_q;

        unique case (sh_state_q)
            ShIdle: begin
                if (!cs_s2_q && armed_q) begin
                    sh_state_d = ShShift;
                    shreg_d    = 16'h0000;
                    bit_cnt_d  = 5'd0;
                    done_d     = 1'b0;
                    armed_d    = 1'b0;
                end
            end
            ShShift: begin
                if (cs_s2_q) begin
                    // Short frames simply die here; nothing was executed.
                    sh_state_d = ShIdle;
                end else if (sck_rise && (bit_cnt_q != FrameBits)) begin
                    shreg_d   = {shreg_q[14:0], mosi_s2_q};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
            default: sh_state_d = ShIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_state_q <= ShIdle;
            shreg_q    <= 16'h0000;
            bit_cnt_q  <= 5'd0;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sh_state_q <= sh_state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM and command execution
    // -------------------------------------------------------------------------
    mode_e      mode_q, mode_d;
    logic [7:0] step_q, step_d;
    logic       load_q, load_d;
    logic [7:0] load_data_q, load_data_d;
    logic       oe_q, oe_d;
    logic       err_q, err_d;

    always_comb begin
        mode_d      = mode_q;
        step_d      = step_q;
        load_d      = 1'b0;
        load_data_d = load_data_q;
        oe_d        = oe_q;
        err_d       = err_q;

        // Step countdown runs every cycle, including one where a non-mode
        // command executes. The last step cycle is the one with step_q == 1.
        if (mode_q == ModeStepping) begin
            if (step_q <= 8'd1) begin
                mode_d = ModeStopped;
                step_d = 8'd0;
            end else begin
                step_d = step_q - 8'd1;
            end
        end

        // Mode-changing commands override the countdown above.
        if (exec) begin
            case (cmd)
                CmdNop: err_d = 1'b0;
                CmdLoad: begin
                    load_d      = 1'b1;
                    load_data_d = data;
                end
                CmdRun: begin
                    mode_d = ModeRunning;
                    step_d = 8'd0;
                end
                CmdStop: begin
                    mode_d = ModeStopped;
                    step_d = 8'd0;
                end
                CmdStep: begin
                    if (data == 8'd0) begin
                        mode_d = ModeStopped;
                        step_d = 8'd0;
                    end else begin
                        mode_d = ModeStepping;
                        step_d = data;
                    end
                end
                CmdOe:   oe_d  = data[0];
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= ModeStopped;
            step_q      <= 8'd0;
            load_q      <= 1'b0;
            load_data_q <= 8'h00;
            oe_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            step_q      <= step_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
            oe_q        <= oe_d;
            err_q       <= err_d;
        end
    end

    assign bus.load      = load_q;
    assign bus.load_data = load_data_q;
    assign bus.en        = (mode_q != ModeStopped);
    assign bus.busy      = (mode_q == ModeStepping);
    assign bus.oe        = oe_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_count_ctrl.sv
// -----------------------------------------------------------------------------
// tb_count_ctrl
// Directed bench for count_ctrl: drives serial frames through the interface
// and checks the counter controls against hand-computed values.
// -----------------------------------------------------------------------------
module tb_count_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_bad;
    int   en_cnt;
    int   busy_cnt;
    int   load_cnt;

    count_ctrl_if bus ();

    count_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Shifts nbits of w MSB first; returns right after the last sck rise,
    // leaving sck high.
    task automatic shift_word(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = w[15-i];
            ticks(3);
            bus.sck = 1'b1;
            if (i != nbits - 1) begin
                ticks(3);
                bus.sck = 1'b0;
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] w);
        bus.cs_n = 1'b0;
        ticks(4);
        shift_word(w, 16);
    endtask

    task automatic finish_frame();
        ticks(3);
        bus.sck = 1'b0;
        ticks(3);
        bus.cs_n = 1'b1;
        ticks(4);
    endtask

    // Counts en/busy/load high cycles over the next n clocks.
    task automatic count_window(input int n);
        en_cnt   = 0;
        busy_cnt = 0;
        load_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            en_cnt   += int'(bus.en);
            busy_cnt += int'(bus.busy);
            load_cnt += int'(bus.load);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.cs_n  = 1'b1;
        bus.sck   = 1'b0;
        bus.mosi  = 1'b0;
        ticks(3);
        check_eq("rst_load",      16'(bus.load),      16'h0);
        check_eq("rst_load_data", 16'(bus.load_data), 16'h00);
        check_eq("rst_en",        16'(bus.en),        16'h0);
        check_eq("rst_oe",        16'(bus.oe),        16'h0);
        check_eq("rst_busy",      16'(bus.busy),      16'h0);
        check_eq("rst_err",       16'(bus.err),       16'h0);
        rst_n = 1'b1;
        ticks(5);

        // LOAD 0xA5: load visible after the 4th edge past the 16th sck rise.
        send_frame(16'h01A5);
        ticks(3);
        check_eq("load_early", 16'(bus.load), 16'h0);
        tick();
        check_eq("load_pulse", 16'(bus.load),      16'h1);
        check_eq("load_data",  16'(bus.load_data), 16'hA5);
        check_eq("load_en",    16'(bus.en),        16'h0);
        tick();
        check_eq("load_end",   16'(bus.load),      16'h0);
        check_eq("load_hold",  16'(bus.load_data), 16'hA5);
        finish_frame();

        // STEP 3, then STEP 0.
        send_frame(16'h0403);
        count_window(20);
        check_eq("step3_en",   16'(en_cnt),   16'd3);
        check_eq("step3_busy", 16'(busy_cnt), 16'd3);
        finish_frame();
        send_frame(16'h0400);
        count_window(20);
        check_eq("step0_en", 16'(en_cnt), 16'd0);
        finish_frame();

        // RUN, STEP 0xC8 while running, STOP mid-step.
        send_frame(16'h0200);
        finish_frame();
        check_eq("run_en",   16'(bus.en),   16'h1);
        check_eq("run_busy", 16'(bus.busy), 16'h0);
        send_frame(16'h04C8);
        ticks(4);
        check_eq("step_busy", 16'(bus.busy), 16'h1);
        finish_frame();
        send_frame(16'h0300);
        ticks(3);
        check_eq("pre_stop_en",   16'(bus.en),   16'h1);
        check_eq("pre_stop_busy", 16'(bus.busy), 16'h1);
        tick();
        check_eq("stop_en",   16'(bus.en),   16'h0);
        check_eq("stop_busy", 16'(bus.busy), 16'h0);
        finish_frame();

        // STEP 0xFF restarted by STEP 3: only 3 more en cycles.
        send_frame(16'h04FF);
        ticks(4);
        finish_frame();
        send_frame(16'h0403);
        ticks(3);
        check_eq("restart_pre", 16'(bus.busy), 16'h1);
        count_window(20);
        check_eq("restart_en", 16'(en_cnt), 16'd3);
        finish_frame();

        // Aborted 9-bit frame, then OE=1.
        bus.cs_n = 1'b0;
        ticks(4);
        shift_word(16'h0501, 9);
        ticks(3);
        bus.sck = 1'b0;
        ticks(3);
        bus.cs_n = 1'b1;
        ticks(6);
        check_eq("abort_oe",  16'(bus.oe),        16'h0);
        check_eq("abort_err", 16'(bus.err),       16'h0);
        check_eq("abort_ld",  16'(bus.load_data), 16'hA5);
        send_frame(16'h0501);
        finish_frame();
        check_eq("oe_set", 16'(bus.oe), 16'h1);

        // Unknown command, then NOP.
        send_frame(16'h7F00);
        count_window(6);
        check_eq("err_load", 16'(load_cnt), 16'd0);
        finish_frame();
        check_eq("err_set", 16'(bus.err),       16'h1);
        check_eq("err_oe",  16'(bus.oe),        16'h1);
        check_eq("err_ld",  16'(bus.load_data), 16'hA5);
        check_eq("err_en",  16'(bus.en),        16'h0);
        send_frame(16'h0000);
        finish_frame();
        check_eq("nop_err", 16'(bus.err), 16'h0);

        // Reset during STEP 0xFF with cs_n held low.
        send_frame(16'h04FF);
        ticks(6);
        check_eq("pre_rst_busy", 16'(bus.busy), 16'h1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_en",   16'(bus.en),        16'h0);
        check_eq("mid_rst_busy", 16'(bus.busy),      16'h0);
        check_eq("mid_rst_oe",   16'(bus.oe),        16'h0);
        check_eq("mid_rst_ld",   16'(bus.load_data), 16'h00);
        check_eq("mid_rst_load", 16'(bus.load),      16'h0);
        check_eq("mid_rst_err",  16'(bus.err),       16'h0);
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        bus.sck = 1'b0;
        ticks(3);
        shift_word(16'h0133, 16);
        count_window(20);
        check_eq("norearm_load", 16'(load_cnt),      16'd0);
        check_eq("norearm_ld",   16'(bus.load_data), 16'h00);
        check_eq("norearm_en",   16'(en_cnt),        16'd0);
        finish_frame();
        send_frame(16'h013C);
        ticks(5);
        check_eq("rearm_ld", 16'(bus.load_data), 16'h3C);
        finish_frame();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
